double_fig_join: RTL
====================

Name: double_fig_join

Overview:
- Serial two-digit entry assembler for the clock's time-set path. Takes BCD digits one at a time, tens first, then ones. Emits the binary value tens*10+ones (0..MAX_VAL) with a one-cycle done pulse.
- Rejects out-of-range digits and values, and aborts on an inter-digit timeout or an explicit clear.
- Sits between the button/keypad digit decoder and the hour/minute/second set registers. It is the inverse direction of the 0..59 to two-segment splitter used on the display path.

Parameters:
- MAX_VAL, 59, largest accepted result (must be ≤ 63; 23 for hours).
- TIMEOUT, 50000000, maximum cycles allowed between tens digit and ones digit (1 s at 50 MHz).
- TO_W, 26, width of the timeout counter (2^TO_W > TIMEOUT).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_digit  input  4  BCD digit, sampled only when i_digit_vld=1.
- i_digit_vld  input  1  one-cycle digit strobe.
- i_clear  input  1  synchronous abort of the entry in progress.
- o_double_fig  output  6  last successfully assembled binary value.
- o_done  output  1  one-cycle pulse: o_double_fig just updated.
- o_err  output  1  one-cycle pulse: entry rejected (bad digit, range, or timeout).
- o_busy  output  1  high while waiting for the ones digit.
- o_tens  output  4  captured tens digit, for display echo while o_busy=1.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; o_double_fig=0, o_done=0, o_err=0, o_busy=0, o_tens=0, timer=0.
- All outputs are registered. o_busy is high exactly in WAIT_ONES.
- Two states: IDLE and WAIT_ONES.
- IDLE, i_digit_vld=1:
  - If i_digit>9 or i_digit*10>MAX_VAL: o_err=1 next cycle; stay IDLE.
  - Otherwise: o_tens<=i_digit, timer<=0, go to WAIT_ONES.
- WAIT_ONES, i_digit_vld=1:
  - sum = o_tens*10 + i_digit, computed in 7 bits as (t<<3)+(t<<1)+d. The range compare is done before truncation to 6 bits.
  - If i_digit>9 or sum>MAX_VAL: o_err=1; o_double_fig unchanged; go IDLE.
  - Otherwise: o_double_fig<=sum[5:0], o_done=1; go IDLE.
- WAIT_ONES, no strobe: timer increments each cycle. When timer==TIMEOUT-1: o_err=1, go IDLE.
- Leaving WAIT_ONES by any path clears o_tens to 0 and timer to 0.
- Latency: o_done or o_err asserts on the clock edge that samples the deciding strobe, i.e. visible the following cycle. o_double_fig updates on the same edge as o_done.
- Priority per cycle, highest first: i_clear, then i_digit_vld, then timeout.
  - i_clear: go IDLE with no o_done and no o_err; any simultaneous strobe is discarded.
  - A strobe in the timeout cycle is accepted; no timeout error.
- i_clear in IDLE has no effect.
- o_done and o_err are never high together; each is high for exactly one cycle per event.
- Back-to-back strobes every cycle are legal: an IDLE→WAIT_ONES→IDLE sequence completes in 2 cycles.
- Reset mid-entry drops the partial digit. o_double_fig returns to 0.

Test Plan (TIMEOUT=16, MAX_VAL=59 unless noted):
- Reset → all outputs 0. Strobe 4 then 7 on consecutive cycles → o_busy=1 and o_tens=4 after first edge; after second edge o_double_fig=47, o_done=1 for 1 cycle, o_busy=0.
- Strobe 6 in IDLE → o_err pulse, stays IDLE. Strobe 5 then 12 → o_err, o_double_fig keeps previous 47. With MAX_VAL=23: strobe 2 then 4 → o_err; strobe 2 then 3 → 23 with o_done.
- Strobe 3, then idle 15 cycles → o_err on cycle 16, o_busy=0. Repeat with the ones strobe (digit 0) landing in the timeout cycle → o_double_fig=30, o_done, no o_err.
- Strobe 1, then i_clear and strobe 9 in the same cycle → IDLE, no o_done/o_err, o_double_fig unchanged. Assert rst_n=0 mid-entry → all outputs 0 asynchronously.
- Exhaustive: enter every value 0..59 as tens/ones digit pairs → o_double_fig equals the value each time. Enter 60..99 → o_err every time.

Source files
------------

// File: rtl/double_fig_join.sv
// Serial two-digit BCD entry assembler: tens digit, then ones digit, yields tens*10+ones.
// Rejects bad digits and out-of-range values, and aborts on timeout or clear.
module double_fig_join #(
  parameter int MAX_VAL = 59,
  parameter int TIMEOUT = 50000000,
  parameter int TO_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_digit,
  input  logic       i_digit_vld,
  input  logic       i_clear,
  output logic [5:0] o_double_fig,
  output logic       o_done,
  output logic       o_err,
  output logic       o_busy,
  output logic [3:0] o_tens
);

  typedef enum logic {IDLE, WAIT_ONES} state_t;

  localparam logic [6:0]      MAX7       = 7'(MAX_VAL);
  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q;
  logic [5:0]      dbl_q;
  logic            done_q;
  logic            err_q;
  logic [3:0]      tens_q;
  logic [TO_W-1:0] timer_q;

  logic [6:0] tens_x10;
  logic [6:0] sum;
  logic       tens_bad;
  logic       ones_bad;
  logic       timer_last;

  // Range checks use the full 7-bit value so that e.g. 64 cannot alias to 0.
  assign tens_x10   = {i_digit, 3'b000} + {2'b00, i_digit, 1'b0};
  assign sum        = {tens_q, 3'b000} + {2'b00, tens_q, 1'b0} + {3'b000, i_digit};
  assign tens_bad   = (i_digit > 4'd9) || (tens_x10 > MAX7);
  assign ones_bad   = (i_digit > 4'd9) || (sum > MAX7);
  assign timer_last = (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dbl_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tens_q  <= '0;
      timer_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (i_digit_vld && !i_clear) begin
          if (tens_bad) begin
            err_q <= 1'b1;
          end else begin
            tens_q  <= i_digit;
            timer_q <= '0;
            state_q <= WAIT_ONES;
          end
        end
      end else begin
        if (i_clear || i_digit_vld || timer_last) begin
          state_q <= IDLE;
          tens_q  <= '0;
          timer_q <= '0;
          // Clear outranks the strobe, which outranks the timeout.
          if (!i_clear) begin
            if (i_digit_vld) begin
              if (ones_bad) begin
                err_q <= 1'b1;
              end else begin
                dbl_q  <= sum[5:0];
                done_q <= 1'b1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign o_double_fig = dbl_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_busy       = (state_q == WAIT_ONES);
  assign o_tens       = tens_q;

endmodule
